// File: rtl/tlv5618_frame_seq.sv
// Paces paired A/B samples into TLV5618 two-word write sequences (B to buffer, then A with update).
// Optional wait-state timeout enabled by defining DAC_TIMEOUT_EN.
module tlv5618_frame_seq #(
    parameter int   UPDATE_DIV = 2500,
    parameter logic SPD        = 1'b1,
    parameter int   TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [11:0] sample_a,
    input  logic [11:0] sample_b,
    output logic        sample_ready,
    output logic        start,
    output logic [15:0] dac_data,
    input  logic        set_done,
    output logic        frame_done,
    output logic        underrun,
    output logic        dac_err
);

    if (UPDATE_DIV < 2 || UPDATE_DIV > 65535 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
        $error("tlv5618_frame_seq: UPDATE_DIV or TIMEOUT out of range");
    end

    localparam logic [15:0] DIV_LAST = 16'(UPDATE_DIV - 1);

    typedef enum logic [2:0] {IDLE, SEND_B, WAIT_B, SEND_A, WAIT_A} state_t;

    state_t      state;
    logic [15:0] rate_cnt;
    logic        tick;
    logic        buf_full;
    logic [11:0] buf_a;
    logic [11:0] buf_b;
    logic [11:0] work_a;
    logic        accept;
    logic        take;
    logic        expired;

    assign tick   = (rate_cnt == DIV_LAST);
    assign accept = sample_valid && sample_ready;
    assign take   = (state == IDLE) && tick && buf_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            rate_cnt <= '0;
        end else begin
            rate_cnt <= tick ? '0 : rate_cnt + 16'd1;
        end
    end

    // sample_ready is kept as its own flop mirroring !buf_full
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full     <= 1'b0;
            sample_ready <= 1'b1;
        end else if (take) begin
            buf_full     <= 1'b0;
            sample_ready <= 1'b1;
        end else if (accept) begin
            buf_full     <= 1'b1;
            sample_ready <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_a <= sample_a;
            buf_b <= sample_b;
        end
        if (take) begin
            work_a <= buf_a;
        end
    end

    // The B word is issued straight from the buffer on the tick so start lands at T+1
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            start      <= 1'b0;
            dac_data   <= 16'h0000;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            start      <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        if (buf_full) begin
                            start    <= 1'b1;
                            dac_data <= {1'b0, SPD, 2'b00, buf_b};
                            state    <= SEND_B;
                        end else begin
                            underrun <= 1'b1;
                        end
                    end
                end
                SEND_B: state <= WAIT_B;
                WAIT_B: begin
                    if (set_done) begin
                        start    <= 1'b1;
                        dac_data <= {1'b1, SPD, 2'b00, work_a};
                        state    <= SEND_A;
                    end else if (expired) begin
                        state <= IDLE;
                    end
                end
                SEND_A: state <= WAIT_A;
                WAIT_A: begin
                    if (set_done) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else if (expired) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DAC_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wait_cnt;

    // wait_cnt holds the number of cycles since the last start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == SEND_B || state == SEND_A) begin
            wait_cnt <= 16'd1;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign expired = (state == WAIT_B || state == WAIT_A) && (wait_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            dac_err <= 1'b0;
        end else begin
            dac_err <= expired && !set_done;
        end
    end
`else
    assign expired = 1'b0;
    assign dac_err = 1'b0;
`endif

endmodule
